// File: rtl/ws2812_bit_encoder.sv
// WS2812 NRZ serialiser: MSB-first cycle-counted bit pulses, one-byte holding register, latch low at frame end.
// Build option WS2812_OUT_INV_EN inverts the registered line for inverting level shifters (idle level 1).
module ws2812_bit_encoder #(
  parameter int T0H_CYC = 32,
  parameter int T1H_CYC = 64,
  parameter int BIT_CYC = 100,
  parameter int RST_CYC = 24000
) (
  input  logic       clk_in,
  input  logic       rst_in,
  input  logic       byte_vld_in,
  input  logic [7:0] byte_data_in,
  input  logic       byte_last_in,
  output logic       byte_rdy_out,
  output logic       ws2812_data_out,
  output logic       busy_out,
  output logic       done_out,
  output logic       underrun_out
);
  localparam int CMAX = (BIT_CYC > RST_CYC) ? BIT_CYC : RST_CYC;
  localparam int CW   = $clog2(CMAX);
  localparam logic [CW-1:0] C_BIT_LAST = CW'(BIT_CYC - 1);
  localparam logic [CW-1:0] C_RST_LAST = CW'(RST_CYC - 1);
  localparam logic [CW-1:0] C_T0H      = CW'(T0H_CYC);
  localparam logic [CW-1:0] C_T1H      = CW'(T1H_CYC);
`ifdef WS2812_OUT_INV_EN
  localparam logic LINE_INV = 1'b1;
`else
  localparam logic LINE_INV = 1'b0;
`endif

  typedef enum logic [1:0] {S_IDLE, S_SEND, S_GAP, S_LATCH} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_cnt, w_cnt_nxt;
  logic [2:0]    r_bit, w_bit_nxt;
  logic [7:0]    r_shift;
  logic          r_last_cur;
  logic          r_full, r_hold_last, r_rdy;
  logic [7:0]    r_hold_data;
  logic          r_line, r_done, r_und;
  logic          w_load, w_done_nxt, w_und_set, w_accept, w_full_nxt, w_line_nxt;

  assign w_accept   = byte_vld_in & r_rdy;
  assign w_full_nxt = w_load ? 1'b0 : (w_accept ? 1'b1 : r_full);
  // Line is computed from the current state/count and registered, so it lags the counter by one clock.
  assign w_line_nxt = (r_state == S_SEND) &&
                      (r_cnt < (r_shift[3'd7 - r_bit] ? C_T1H : C_T0H));

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt + 1'b1;
    w_bit_nxt   = r_bit;
    w_load      = 1'b0;
    w_done_nxt  = 1'b0;
    w_und_set   = 1'b0;
    case (r_state)
      S_IDLE: begin
        w_cnt_nxt = '0;
        if (r_full) begin
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end
      end
      S_SEND: begin
        if (r_cnt == C_BIT_LAST) begin
          w_cnt_nxt = '0;
          w_bit_nxt = r_bit + 3'd1;
          if (r_bit == 3'd7) begin
            if (r_last_cur)  w_state_nxt = S_LATCH;
            else if (r_full) w_load      = 1'b1;
            else             w_state_nxt = S_GAP;
          end
        end
      end
      S_GAP: begin
        if (r_full && (r_cnt != C_RST_LAST)) begin
          w_und_set   = 1'b1;
          w_load      = 1'b1;
          w_state_nxt = S_SEND;
        end else if (r_cnt == C_RST_LAST) begin
          w_und_set   = 1'b1;
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      S_LATCH: begin
        if (r_cnt == C_RST_LAST) begin
          w_done_nxt  = 1'b1;
          w_cnt_nxt   = '0;
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_load) begin
      w_cnt_nxt = '0;
      w_bit_nxt = 3'd0;
    end
  end

  always_ff @(posedge clk_in) begin
    if (rst_in) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_bit       <= 3'd0;
      r_shift     <= 8'd0;
      r_last_cur  <= 1'b0;
      r_full      <= 1'b0;
      r_hold_data <= 8'd0;
      r_hold_last <= 1'b0;
      r_rdy       <= 1'b0;
      r_line      <= LINE_INV;
      r_done      <= 1'b0;
      r_und       <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_bit   <= w_bit_nxt;
      r_done  <= w_done_nxt;
      r_und   <= r_und | w_und_set;
      r_line  <= w_line_nxt ^ LINE_INV;
      r_full  <= w_full_nxt;
      r_rdy   <= ~w_full_nxt;
      if (w_accept) begin
        r_hold_data <= byte_data_in;
        r_hold_last <= byte_last_in;
      end
      if (w_load) begin
        r_shift    <= r_hold_data;
        r_last_cur <= r_hold_last;
      end
    end
  end

  assign byte_rdy_out    = r_rdy;
  assign ws2812_data_out = r_line;
  assign busy_out        = (r_state != S_IDLE) | r_full;
  assign done_out        = r_done;
  assign underrun_out    = r_und;
endmodule

// File: tb/tb_ws2812_bit_encoder.sv
// Bench for ws2812_bit_encoder: per-byte timeline model (accept/load edges, waveform arithmetic) vs DUT each cycle.
module tb_ws2812_bit_encoder;
  localparam int T0H = 32, T1H = 64, BITC = 100, RSTC = 1000;
  localparam int MAXE = 20000, MAXB = 8;
`ifdef WS2812_OUT_INV_EN
  localparam logic INV = 1'b1;
`else
  localparam logic INV = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst, vld, last;
  logic [7:0] data;
  logic rdy, line, busy, done, und;

  ws2812_bit_encoder #(.T0H_CYC(T0H), .T1H_CYC(T1H), .BIT_CYC(BITC), .RST_CYC(RSTC)) dut (
    .clk_in(clk), .rst_in(rst), .byte_vld_in(vld), .byte_data_in(data), .byte_last_in(last),
    .byte_rdy_out(rdy), .ws2812_data_out(line), .busy_out(busy), .done_out(done),
    .underrun_out(und));

  always #5 clk = ~clk;

  int n_cmp = 0, n_bad = 0;
  bit exp_und_prev;
  logic [7:0] sb_data[MAXB];
  bit   sb_last[MAXB];
  int   sb_gap[MAXB];
  bit ex_line[MAXE], ex_done[MAXE], ex_busy[MAXE], ex_rdy[MAXE];

  function automatic int imax(input int x, input int y); return (x > y) ? x : y; endfunction
  function automatic int imin(input int x, input int y); return (x < y) ? x : y; endfunction

  task automatic mark_busy(input int lo, input int hi);
    for (int e = lo; e < hi && e < MAXE; e++) ex_busy[e] = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1; vld = 1'b0; data = 8'h00; last = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    exp_und_prev = 1'b0;
  endtask

  // Edges are numbered from 1 after the call; DUT must be idle with an empty holding register.
  // Byte k is offered at (end of previous byte + gap), or immediately when gap < 0.
  task automatic run_sched(input int n, input int stop_e, input string tag);
    int a[MAXB], ld[MAXB], off[MAXB];
    int E, T, uf, th, p;
    logic [7:0] bv;
    bit eu;
    for (int i = 0; i < MAXE; i++) begin
      ex_line[i] = 1'b0; ex_done[i] = 1'b0; ex_busy[i] = 1'b0; ex_rdy[i] = 1'b1;
    end
    uf = MAXE;
    for (int k = 0; k < n; k++) begin
      if (k == 0) begin
        off[k] = 1; a[k] = 1; ld[k] = 2;
      end else begin
        E      = ld[k-1] + 8*BITC;
        off[k] = (sb_gap[k] < 0) ? 1 : E + sb_gap[k];
        a[k]   = imax(off[k], ld[k-1] + 1);
        if (sb_last[k-1]) begin
          ld[k] = imax(a[k] + 1, E + RSTC + 1);
          ex_done[E+RSTC] = 1'b1; mark_busy(E, E + RSTC);
        end else if (a[k] <= E - 1) begin
          ld[k] = E;
        end else if (a[k] <= E + RSTC - 2) begin
          ld[k] = a[k] + 1; uf = imin(uf, ld[k]); mark_busy(E, ld[k]);
        end else begin
          ld[k] = imax(a[k] + 1, E + RSTC + 1); uf = imin(uf, E + RSTC);
          ex_done[E+RSTC] = 1'b1; mark_busy(E, E + RSTC);
        end
      end
      mark_busy(a[k], ld[k] + 8*BITC);
      for (int e = a[k]; e < ld[k]; e++) ex_rdy[e] = 1'b0;
      bv = sb_data[k];
      for (int j = 0; j < 8*BITC; j++) begin
        th = bv[3'(7 - j/BITC)] ? T1H : T0H;
        ex_line[ld[k]+1+j] = ((j % BITC) < th);
      end
    end
    E = ld[n-1] + 8*BITC;
    ex_done[E+RSTC] = 1'b1; mark_busy(E, E + RSTC);
    if (!sb_last[n-1]) uf = imin(uf, E + RSTC);
    T = (stop_e > 0) ? stop_e : E + RSTC + 3;
    p = 0;
    for (int e = 1; e <= T; e++) begin
      while (p < n && a[p] < e) p++;
      if (p < n && off[p] <= e) begin
        vld = 1'b1; data = sb_data[p]; last = sb_last[p];
      end else begin
        vld = 1'b0; data = 8'($urandom); last = 1'($urandom);
      end
      @(posedge clk); @(negedge clk);
      eu = exp_und_prev | (e >= uf);
      n_cmp += 5;
      if (line !== (ex_line[e] ^ INV)) begin
        n_bad++; $display("FAIL %s line @edge %0d: got %b want %b", tag, e, line, ex_line[e] ^ INV);
      end
      if (done !== ex_done[e]) begin
        n_bad++; $display("FAIL %s done @edge %0d: got %b want %b", tag, e, done, ex_done[e]);
      end
      if (busy !== ex_busy[e]) begin
        n_bad++; $display("FAIL %s busy @edge %0d: got %b want %b", tag, e, busy, ex_busy[e]);
      end
      if (rdy !== ex_rdy[e]) begin
        n_bad++; $display("FAIL %s rdy @edge %0d: got %b want %b", tag, e, rdy, ex_rdy[e]);
      end
      if (und !== eu) begin
        n_bad++; $display("FAIL %s underrun @edge %0d: got %b want %b", tag, e, und, eu);
      end
    end
    vld = 1'b0;
    if (uf <= T) exp_und_prev = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; vld = 1'b1; data = 8'hFF; last = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp += 5;
    if (line !== INV)   begin n_bad++; $display("FAIL reset line: got %b want %b", line, INV); end
    if (rdy !== 1'b0)   begin n_bad++; $display("FAIL reset rdy: got %b want 0", rdy); end
    if (busy !== 1'b0)  begin n_bad++; $display("FAIL reset busy: got %b want 0", busy); end
    if (done !== 1'b0)  begin n_bad++; $display("FAIL reset done: got %b want 0", done); end
    if (und !== 1'b0)   begin n_bad++; $display("FAIL reset underrun: got %b want 0", und); end
    vld = 1'b0; rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp += 2;
    if (rdy !== 1'b1)   begin n_bad++; $display("FAIL post-reset rdy: got %b want 1", rdy); end
    if (busy !== 1'b0)  begin n_bad++; $display("FAIL post-reset busy: got %b want 0", busy); end
    exp_und_prev = 1'b0;
  endtask

  task automatic test_single();
    sb_data[0] = 8'hA5; sb_last[0] = 1'b1; sb_gap[0] = -1;
    run_sched(1, 0, "single");
  endtask

  task automatic test_back_to_back();
    sb_data[0] = 8'hFF; sb_last[0] = 1'b0; sb_gap[0] = -1;
    sb_data[1] = 8'h00; sb_last[1] = 1'b0; sb_gap[1] = -1;
    sb_data[2] = 8'h81; sb_last[2] = 1'b1; sb_gap[2] = -1;
    run_sched(3, 0, "b2b");
  endtask

  task automatic test_underrun();
    int gaps[3];
    gaps[0] = 500; gaps[1] = RSTC - 2; gaps[2] = RSTC;
    for (int i = 0; i < 3; i++) begin
      do_reset();
      sb_data[0] = 8'h3C; sb_last[0] = 1'b0; sb_gap[0] = -1;
      sb_data[1] = 8'hC3; sb_last[1] = 1'b1; sb_gap[1] = gaps[i];
      run_sched(2, 0, "underrun");
    end
  endtask

  task automatic test_midreset();
    do_reset();
    sb_data[0] = 8'hA5; sb_last[0] = 1'b1; sb_gap[0] = -1;
    run_sched(1, 2 + 1 + 3*BITC + 10, "midreset");
    rst = 1'b1; vld = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp += 4;
    if (line !== INV)  begin n_bad++; $display("FAIL midreset line: got %b want %b", line, INV); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL midreset done: got %b want 0", done); end
    if (busy !== 1'b0) begin n_bad++; $display("FAIL midreset busy: got %b want 0", busy); end
    if (rdy !== 1'b0)  begin n_bad++; $display("FAIL midreset rdy: got %b want 0", rdy); end
    rst = 1'b0;
    @(posedge clk); @(negedge clk);
    n_cmp += 2;
    if (rdy !== 1'b1)  begin n_bad++; $display("FAIL midreset rdy after: got %b want 1", rdy); end
    if (done !== 1'b0) begin n_bad++; $display("FAIL midreset done after: got %b want 0", done); end
    exp_und_prev = 1'b0;
    run_sched(1, 0, "midreset-fresh");
  endtask

  task automatic test_latch_accept();
    do_reset();
    sb_data[0] = 8'h5A; sb_last[0] = 1'b1; sb_gap[0] = -1;
    sb_data[1] = 8'h96; sb_last[1] = 1'b1; sb_gap[1] = 300;
    run_sched(2, 0, "latch-accept");
  endtask

  task automatic test_random();
    int n, r;
    for (int it = 0; it < 2; it++) begin
      do_reset();
      n = 3 + int'($urandom_range(0, 2));
      for (int k = 0; k < n; k++) begin
        sb_data[k] = 8'($urandom);
        sb_last[k] = (k == n - 1) || ($urandom_range(0, 3) == 0);
        r = int'($urandom_range(0, 3));
        sb_gap[k] = (r < 2) ? -1 : (r == 2) ? int'($urandom_range(0, 60))
                                            : int'($urandom_range(RSTC - 4, RSTC + 40));
      end
      run_sched(n, 0, "random");
    end
  endtask

  initial begin
    rst = 1'b1; vld = 1'b0; data = 8'h00; last = 1'b0; exp_und_prev = 1'b0;
    test_reset();
    test_single();
    test_back_to_back();
    test_underrun();
    test_midreset();
    test_latch_accept();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/ws2812_bit_encoder.md
# ws2812_bit_encoder

Serialises a byte stream into the WS2812 single-wire NRZ waveform: MSB-first bits with a cycle-counted high/low pulse per bit, then a latch (reset) low period at the end of each frame. It sits downstream of the per-layer frame buffer read-out in each `layer_out` channel, so one instance drives one `ws2812_data_out[i]` line. It runs on `sys_clk` (PLL output, 80 MHz nominal). A one-byte holding register gives gap-free streaming across byte boundaries.

## Interface
- `T0H_CYC`, 32: high time of a 0 bit, in clocks (0.4 µs @ 80 MHz)
- `T1H_CYC`, 64: high time of a 1 bit, in clocks (0.8 µs)
- `BIT_CYC`, 100: total bit period, in clocks (1.25 µs); T0H_CYC < T1H_CYC < BIT_CYC
- `RST_CYC`, 24000: latch low time, in clocks (300 µs)
- `clk_in` in 1: system clock
- `rst_in` in 1: reset, synchronous, active-high
- `byte_vld_in` in 1: input byte valid
- `byte_data_in` in 8: pixel byte (G, R, B order is the producer's responsibility)
- `byte_last_in` in 1: qualifies last byte of frame; sampled with the byte
- `byte_rdy_out` out 1: holding register empty; transfer occurs when vld & rdy
- `ws2812_data_out` out 1: serial LED line
- `busy_out` out 1: state ≠ IDLE or holding register full
- `done_out` out 1: one-cycle pulse when a latch period completes
- `underrun_out` out 1: sticky; set when the shifter ran dry mid-frame

## Operation
- Holding register `hold` (8 data bits + last flag + full flag). `byte_rdy_out` = registered `~full`. There is no bypass.
- State machine:
  - IDLE: line low. If `full`, load the shifter from `hold`, clear `full`, and go to SEND.
  - SEND: bit counter 0..7 and cycle counter 0..BIT_CYC-1. Line is high while cnt < (bit ? T1H_CYC : T0H_CYC), otherwise low. At cnt = BIT_CYC-1 of bit 7:
    - If the byte was last, go to LATCH.
    - Else if `full`, reload and stay in SEND with no idle cycle.
    - Else go to GAP.
  - GAP: line low; counter runs.
    - If `full` before cnt reaches RST_CYC-1: set `underrun_out`, load, and go to SEND.
    - At RST_CYC-1: set `underrun_out`, pulse `done_out`, and go to IDLE.
  - LATCH: line low for RST_CYC cycles. At the final cycle, pulse `done_out` and go to IDLE. `hold` may accept the next frame's first byte during LATCH; shifting waits for IDLE.
- Load and accept in the same cycle are mutually exclusive, because rdy is registered. A byte offered on the load cycle is accepted one cycle later.
- `underrun_out` is cleared only by reset.
- Counter width is $clog2(max(BIT_CYC, RST_CYC)) bits (15 bits by default). No wrap occurs within a state.

## Timing
- Reset values:
  - `ws2812_data_out` = 0 (1 with inversion enabled)
  - `byte_rdy_out` = 0 while `rst_in` is high, 1 on the first cycle after
  - `busy_out` = 0, `done_out` = 0, `underrun_out` = 0
  - state = IDLE, all counters 0
- Reset mid-bit: on the clock after `rst_in` is asserted, the line is at its idle level and the in-flight byte and `hold` are discarded. No `done_out`.
- Latency: accept at edge N (IDLE) → `full` at N+1 → load at N+1 → first line high at N+2.
- The output is registered. Each bit occupies exactly BIT_CYC clocks. A byte is 8×BIT_CYC = 800 clocks.
- `done_out` is asserted in the cycle after the final latch-low cycle. `busy_out` falls in the same cycle unless `hold` is full.

## Configuration
- `WS2812_OUT_INV_EN` defined: `ws2812_data_out` is inverted at the output register, for inverting level shifters. Idle/latch level is 1 and reset value is 1.
- Not defined: true polarity. Idle/latch level is 0.

## Test plan
- Single byte 0xA5 with last=1:
  - High widths are 64,32,64,32,32,64,32,64, each bit period 100 clocks.
  - Then 24000 low cycles, then `done_out` for 1 cycle.
  - `underrun_out` stays 0.
- Three bytes 0xFF,0x00,0x81 (last on the third), offered back-to-back: 2400 contiguous bit clocks with no extra low cycles between bytes, and `byte_rdy_out` never stalls the pipe beyond the hold depth.
- Underrun:
  - Second byte offered 500 clocks after the first byte ends: line low 500 cycles, `underrun_out`=1, second byte transmitted normally.
  - Repeat with a 24000-cycle gap: `done_out` pulses and the state returns to IDLE.
- `rst_in` asserted at bit 3 mid-high: line low the next cycle, no `done_out`. A fresh byte afterwards reproduces the single-byte waveform.
- Accept during LATCH: next-frame byte accepted with `byte_rdy_out` then 0. Its first high edge occurs 1 cycle after `done_out`'s IDLE load, not earlier.
- Build with `WS2812_OUT_INV_EN`: repeat the first test. The waveform is exactly complemented, and the reset value is 1.
